// File: rtl/div_unit_pkg.sv
// div_unit_pkg
// Shared constants for the EX-stage divider: result-ready levels, the
// DIV/DIVU control encoding and the 2-bit divider state encodings.
// No ports; imported by div_unit.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // div_ready levels seen by the hazard unit
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // signed_div encoding: DIV is signed, DIVU is unsigned
  localparam logic DIV_CONTROL  = 1'b1;
  localparam logic DIVU_CONTROL = 1'b0;

  // DivByZero is resolved at accept time (the result is written on the
  // accept edge), so the FSM never rests in that encoding.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// div_step
// One combinational iteration of a radix-2 restoring divide.
// Ports:
//   i_rem  partial remainder before this iteration
//   i_dvd  dividend/quotient shift register before this iteration
//   i_dvs  divisor magnitude
//   o_rem  partial remainder after this iteration
//   o_dvd  shift register after this iteration (new quotient bit in LSB)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dvd,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_dvd
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // The shifted partial remainder can momentarily need WIDTH+1 bits
  // (remainder < divisor <= 2^WIDTH-1), so the trial compare is done at
  // WIDTH+1 bits. When the subtraction does not borrow the true difference
  // is below the divisor, so a WIDTH-bit subtract yields it exactly.
  assign w_shifted = {i_rem, i_dvd[WIDTH-1]};
  assign w_fits    = (w_shifted >= {1'b0, i_dvs});
  assign w_diff    = w_shifted[WIDTH-1:0] - i_dvs;

  assign o_rem = w_fits ? w_diff : w_shifted[WIDTH-1:0];
  assign o_dvd = {i_dvd[WIDTH-2:0], w_fits};

endmodule

// File: rtl/div_unit.sv
// div_unit
// Multi-cycle signed/unsigned radix-2 restoring divider for the EX stage.
// Answers the hazard unit's held div_start with a one-cycle div_ready and a
// {remainder, quotient} result for HI/LO.
// Ports:
//   clk         pipeline clock
//   rst_n       asynchronous active-low reset
//   div_start   level request, held until div_ready
//   signed_div  1 = DIV (signed), 0 = DIVU
//   opdata1     dividend, sampled at accept
//   opdata2     divisor, sampled at accept
//   annul       flush/exception cancel, aborts any operation
//   div_ready   result valid for exactly one cycle
//   result      {remainder (HI), quotient (LO)}, held until the next result
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               div_start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic               div_ready,
  output logic [2*WIDTH-1:0] result
);

  div_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_rem, w_rem_nxt;
  logic [WIDTH-1:0]   r_dvd, w_dvd_nxt;
  logic [WIDTH-1:0]   r_dvs, w_dvs_nxt;
  logic               r_qneg, w_qneg_nxt;
  logic               r_rneg, w_rneg_nxt;
  logic               r_ready, w_ready_nxt;
  logic [2*WIDTH-1:0] r_result, w_result_nxt;

  logic               w_signed;
  logic               w_sign1;
  logic               w_sign2;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_dvd;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_last;

  // Operand magnitudes; for DIVU the raw bit patterns are used.
  assign w_signed = (signed_div == DIV_CONTROL);
  assign w_sign1  = w_signed & opdata1[WIDTH-1];
  assign w_sign2  = w_signed & opdata2[WIDTH-1];
  assign w_abs1   = w_sign1 ? -opdata1 : opdata1;
  assign w_abs2   = w_sign2 ? -opdata2 : opdata2;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_dvd (r_dvd),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_dvd (w_step_dvd)
  );

  // Sign correction is applied to the final iteration's output so the
  // corrected result can be registered on the same edge that enters DivEnd.
  // Negating 0x80000000 wraps to itself, giving the two's-complement
  // overflow result for MIN/-1 without a trap.
  assign w_quot_fix = r_qneg ? -w_step_dvd : w_step_dvd;
  assign w_rem_fix  = r_rneg ? -w_step_rem : w_step_rem;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_dvd_nxt    = r_dvd;
    w_dvs_nxt    = r_dvs;
    w_qneg_nxt   = r_qneg;
    w_rneg_nxt   = r_rneg;
    w_ready_nxt  = DIV_RESULT_NOT_READY;
    w_result_nxt = r_result;

    case (r_state)
      DivFree: begin
        if (div_start && !annul) begin
          if (opdata2 == '0) begin
            // Divide-by-zero is answered straight from accept.
            w_result_nxt = {opdata1, {WIDTH{1'b1}}};
            w_ready_nxt  = DIV_RESULT_READY;
            w_state_nxt  = DivEnd;
          end else begin
            w_dvd_nxt   = w_abs1;
            w_dvs_nxt   = w_abs2;
            w_qneg_nxt  = w_sign1 ^ w_sign2;
            w_rneg_nxt  = w_sign1;
            w_rem_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = DivOn;
          end
        end
      end

      DivOn: begin
        // A flush (annul) or a withdrawn request drops the operation.
        if (annul || !div_start) begin
          w_state_nxt = DivFree;
        end else begin
          w_rem_nxt = w_step_rem;
          w_dvd_nxt = w_step_dvd;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_last) begin
            w_result_nxt = {w_rem_fix, w_quot_fix};
            w_ready_nxt  = DIV_RESULT_READY;
            w_state_nxt  = DivEnd;
          end
        end
      end

      // The DivEnd cycle is the one in which div_ready is visible.
      DivEnd:  w_state_nxt = DivFree;

      default: w_state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_ready  <= DIV_RESULT_NOT_READY;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
      r_qneg   <= w_qneg_nxt;
      r_rneg   <= w_rneg_nxt;
      r_ready  <= w_ready_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign div_ready = r_ready;
  assign result    = r_result;

endmodule
